// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_decoder
//  Function : Assembles 5-byte command frames (SYNC, OPCODE, ADDR, VALUE,
//             CHECK) from UART receive bytes. It pulses cmd_valid for a good
//             frame, and it reports, classifies and counts bad frames.
//  Revision : 1.0  initial release
// ============================================================================
module uart_cmd_decoder #(
  parameter int                       TIMEOUT_WIDTH = 20,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT       = 20'd999999,
  parameter logic [7:0]               SYNC_BYTE     = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic       cmd_valid,
  output logic [7:0] cmd_opcode,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_value,
  output logic       frame_error,
  output logic [1:0] error_code,
  output logic [7:0] error_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_VALUE  = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  localparam logic [1:0] C_ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] C_ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] C_ERR_OPCODE   = 2'd3;
  localparam logic [TIMEOUT_WIDTH-1:0] C_TMO_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   r_state;
  state_t                   w_state_next;
  logic [7:0]               r_sh_opcode;
  logic [7:0]               r_sh_addr;
  logic [7:0]               r_sh_value;
  logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt;
  logic                     w_load_cmd;
  logic                     w_err_fire;
  logic [1:0]               w_err_cause;
  logic                     w_timeout_hit;
  logic [7:0]               w_chk;
  logic                     w_opcode_ok;

  // A pending byte always takes priority over an expiring inter-byte timer.
  assign w_timeout_hit = (r_state != ST_HUNT) && !rx_strobe && (r_tmo_cnt == TIMEOUT);
  assign w_chk         = r_sh_opcode ^ r_sh_addr ^ r_sh_value;
  assign w_opcode_ok   = (r_sh_opcode >= 8'h01) && (r_sh_opcode <= 8'h04);
  assign busy          = (r_state != ST_HUNT);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_HUNT;
    else       r_state <= w_state_next;
  end

  // Next-state logic with frame accept / reject decisions.
  always_comb begin
    w_state_next = r_state;
    w_load_cmd   = 1'b0;
    w_err_fire   = 1'b0;
    w_err_cause  = 2'd0;
    case (r_state)
      ST_HUNT: begin
        if (rx_strobe && (rx_data == SYNC_BYTE)) w_state_next = ST_OPCODE;
      end
      ST_OPCODE: begin
        if (rx_strobe) w_state_next = ST_ADDR;
        else if (w_timeout_hit) begin
          w_err_fire   = 1'b1;
          w_err_cause  = C_ERR_TIMEOUT;
          w_state_next = ST_HUNT;
        end
      end
      ST_ADDR: begin
        if (rx_strobe) w_state_next = ST_VALUE;
        else if (w_timeout_hit) begin
          w_err_fire   = 1'b1;
          w_err_cause  = C_ERR_TIMEOUT;
          w_state_next = ST_HUNT;
        end
      end
      ST_VALUE: begin
        if (rx_strobe) w_state_next = ST_CHECK;
        else if (w_timeout_hit) begin
          w_err_fire   = 1'b1;
          w_err_cause  = C_ERR_TIMEOUT;
          w_state_next = ST_HUNT;
        end
      end
      ST_CHECK: begin
        if (rx_strobe) begin
          w_state_next = ST_HUNT;
          if (rx_data != w_chk) begin
            w_err_fire  = 1'b1;
            w_err_cause = C_ERR_CHECKSUM;
          end else if (!w_opcode_ok) begin
            w_err_fire  = 1'b1;
            w_err_cause = C_ERR_OPCODE;
          end else begin
            w_load_cmd = 1'b1;
          end
        end else if (w_timeout_hit) begin
          w_err_fire   = 1'b1;
          w_err_cause  = C_ERR_TIMEOUT;
          w_state_next = ST_HUNT;
        end
      end
      default: w_state_next = ST_HUNT;
    endcase
  end

  // Shadow registers capture frame fields as they arrive; SYNC_BYTE is plain data here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sh_opcode <= 8'h00;
      r_sh_addr   <= 8'h00;
      r_sh_value  <= 8'h00;
    end else if (rx_strobe) begin
      if (r_state == ST_OPCODE) r_sh_opcode <= rx_data;
      if (r_state == ST_ADDR)   r_sh_addr   <= rx_data;
      if (r_state == ST_VALUE)  r_sh_value  <= rx_data;
    end
  end

  // Inter-byte idle timer: runs only inside a frame, restarts on each byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                                 r_tmo_cnt <= '0;
    else if ((r_state == ST_HUNT) || rx_strobe || w_timeout_hit) r_tmo_cnt <= '0;
    else                                                       r_tmo_cnt <= r_tmo_cnt + C_TMO_ONE;
  end

  // Command outputs move only when a good frame completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      cmd_opcode <= 8'h00;
      cmd_addr   <= 8'h00;
      cmd_value  <= 8'h00;
    end else begin
      cmd_valid <= w_load_cmd;
      if (w_load_cmd) begin
        cmd_opcode <= r_sh_opcode;
        cmd_addr   <= r_sh_addr;
        cmd_value  <= r_sh_value;
      end
    end
  end

  // Error pulse, held cause and saturating error counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_error <= 1'b0;
      error_code  <= 2'd0;
      error_count <= 8'h00;
    end else begin
      frame_error <= w_err_fire;
      if (w_err_fire) begin
        error_code <= w_err_cause;
        if (error_count != 8'hFF) error_count <= error_count + 8'h01;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_decoder
//  Function : Directed, self-checking bench for uart_cmd_decoder with
//             hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       cmd_valid;
  logic [7:0] cmd_opcode;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_value;
  logic       frame_error;
  logic [1:0] error_code;
  logic [7:0] error_count;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cv_cnt = 0;     // cycles with cmd_valid high
  int fe_cnt = 0;     // cycles with frame_error high
  int both_cnt = 0;   // cycles with both high

  uart_cmd_decoder #(
    .TIMEOUT_WIDTH(20),
    .TIMEOUT      (20'd16),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_strobe  (rx_strobe),
    .cmd_valid  (cmd_valid),
    .cmd_opcode (cmd_opcode),
    .cmd_addr   (cmd_addr),
    .cmd_value  (cmd_value),
    .frame_error(frame_error),
    .error_code (error_code),
    .error_count(error_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (cmd_valid)                cv_cnt   <= cv_cnt + 1;
    if (frame_error)              fe_cnt   <= fe_cnt + 1;
    if (cmd_valid && frame_error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte, strobe held for exactly one cycle; consecutive calls are back-to-back.
  task automatic send(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(negedge clock);
    rx_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] ad,
                       input logic [7:0] va, input logic [7:0] ck);
    send(8'hA5); send(op); send(ad); send(va); send(ck);
  endtask

  int cv0, fe0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rx_strobe = 1'b0; rx_data = 8'h00;
    idle(2);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_cmd",    {cmd_opcode, cmd_addr, cmd_value, 7'd0, cmd_valid}, 32'd0);
    check("rst_err",    {22'd0, error_code, error_count}, 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: good WRITE frame
    frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    check("t1_valid_now", {31'd0, cmd_valid}, 32'd1);
    idle(2);
    check("t1_cv_cnt",  cv_cnt, 1);
    check("t1_fields",  {8'd0, cmd_opcode, cmd_addr, cmd_value}, 32'h0001103C);
    check("t1_errcnt",  error_count, 8'd0);
    check("t1_busy",    busy, 1'b0);

    // 2: checksum error
    cv0 = cv_cnt;
    frame(8'h02, 8'h00, 8'h00, 8'h00);
    check("t2_fe_now",  {31'd0, frame_error}, 32'd1);
    idle(2);
    check("t2_code",    error_code, 2'd1);
    check("t2_fields",  {8'd0, cmd_opcode, cmd_addr, cmd_value}, 32'h0001103C);
    check("t2_errcnt",  error_count, 8'd1);
    check("t2_no_cv",   cv_cnt, cv0);

    // 3: bad opcode, then good START
    frame(8'h09, 8'h00, 8'h00, 8'h09);
    idle(2);
    check("t3_code",    error_code, 2'd3);
    check("t3_errcnt",  error_count, 8'd2);
    frame(8'h03, 8'h00, 8'h00, 8'h03);
    idle(2);
    check("t3_opcode",  cmd_opcode, 8'h03);
    check("t3_cv_cnt",  cv_cnt, cv0 + 1);

    // 4a: timeout fires exactly TIMEOUT+1 clocks after last strobe
    fe0 = fe_cnt;
    send(8'hA5); send(8'h01);
    idle(16);
    check("t4_no_fe_16", {31'd0, frame_error}, 32'd0);
    idle(1);
    check("t4_fe_17",   {31'd0, frame_error}, 32'd1);
    check("t4_code",    error_code, 2'd2);
    idle(1);
    check("t4_fe_width", {31'd0, frame_error}, 32'd0);
    check("t4_busy",    busy, 1'b0);
    check("t4_errcnt",  error_count, 8'd3);

    // 4b: byte on clock 16 keeps the frame alive
    fe0 = fe_cnt; cv0 = cv_cnt;
    send(8'hA5); send(8'h01);
    idle(15);
    send(8'h22);
    check("t4b_busy",   busy, 1'b1);
    send(8'h33); send(8'h10);
    idle(2);
    check("t4b_no_fe",  fe_cnt, fe0);
    check("t4b_cv",     cv_cnt, cv0 + 1);
    check("t4b_fields", {8'd0, cmd_opcode, cmd_addr, cmd_value}, 32'h00012233);

    // 5: garbage then SYNC bytes used as data
    fe0 = fe_cnt; cv0 = cv_cnt;
    send(8'h00); send(8'hFF); send(8'h13);
    check("t5_hunt",    busy, 1'b0);
    frame(8'h01, 8'hA5, 8'hA5, 8'h01);
    idle(2);
    check("t5_fields",  {8'd0, cmd_opcode, cmd_addr, cmd_value}, 32'h0001A5A5);
    check("t5_cv",      cv_cnt, cv0 + 1);
    check("t5_no_fe",   fe_cnt, fe0);

    // 6: saturation then mid-frame reset
    fe0 = fe_cnt;
    for (int i = 0; i < 260; i++) frame(8'h02, 8'h00, 8'h00, 8'h00);
    idle(2);
    check("t6_fe_pulses", fe_cnt, fe0 + 260);
    check("t6_sat",     error_count, 8'hFF);
    check("t6_both",    both_cnt, 0);
    fe0 = fe_cnt;
    send(8'hA5); send(8'h01);
    check("t6_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_rst_busy",   busy, 1'b0);
    check("t6_rst_errcnt", error_count, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    idle(20);
    check("t6_no_fe",   fe_cnt, fe0);
    cv0 = cv_cnt;
    frame(8'h04, 8'h07, 8'h08, 8'h0B);
    idle(2);
    check("t6_cv",      cv_cnt, cv0 + 1);
    check("t6_fields",  {8'd0, cmd_opcode, cmd_addr, cmd_value}, 32'h00040708);
    check("t6_errcnt",  error_count, 8'h00);
    check("both_never", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
